// File: rtl/neuron_pkg.sv
// Shared Q3.12 number format and spike encoder types used across the neuron core slice.
package neuron_pkg;
  localparam int INT_W = 3;
  localparam int FRC_W = 12;
  localparam int W     = 1 + INT_W + FRC_W;
  localparam logic signed [W-1:0] Q_ONE = 16'sd4096;
  localparam int TS_W  = 16;

  typedef enum logic [1:0] {ARMED, REFRACT, WAIT_LO} enc_state_t;
  typedef logic [TS_W-1:0] ts_t;
endpackage

// File: rtl/spike_event_encoder_if.sv
// Signal bundle between the neuron core, the spike encoder and the event consumer.
interface spike_event_encoder_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned TS_W = 16
);
  import neuron_pkg::*;

  logic                 v_valid;
  logic signed [W-1:0]  v_in;
  logic signed [W-1:0]  thr_hi;
  logic signed [W-1:0]  thr_lo;
  logic                 spike;
  // Event stream: a transfer happens on a cycle with ev_valid & ev_ready; once
  // ev_valid is high it stays high and ev_ts stays stable until that transfer.
  logic                 ev_valid;
  logic                 ev_ready;
  logic [TS_W-1:0]      ev_ts;
  logic                 overflow;
  logic [7:0]           drop_cnt;
  enc_state_t           dbg_state;

  modport master (
    output v_valid, v_in, thr_hi, thr_lo, ev_ready,
    input  spike, ev_valid, ev_ts, overflow, drop_cnt, dbg_state
  );

  modport slave (
    input  v_valid, v_in, thr_hi, thr_lo, ev_ready,
    output spike, ev_valid, ev_ts, overflow, drop_cnt, dbg_state
  );
endinterface

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the oldest entry while not empty.
module event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/spike_event_encoder.sv
// Threshold-crossing spike detector with refractory/hysteresis re-arm and a
// timestamped event queue toward the spike router.
module spike_event_encoder #(
  parameter int unsigned W          = 16,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REFRACT    = 8
) (
  input logic                  clk,
  input logic                  rst,
  spike_event_encoder_if.slave bus
);
  import neuron_pkg::*;

  localparam int CNT_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  enc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TS_W-1:0]  ts_q;
  logic             fire;
  logic             spike_q;
  logic             overflow_q;
  logic [7:0]       drop_q;
  logic             pop, full, empty, drop;
  logic [TS_W-1:0]  head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARMED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (bus.v_valid) begin
      case (state_q)
        ARMED: begin
          if (bus.v_in >= bus.thr_hi) begin
            fire = 1'b1;
            if (REFRACT > 0) begin
              state_d = neuron_pkg::REFRACT;
              cnt_d   = CNT_W'(REFRACT - 1);
            end else begin
              state_d = WAIT_LO;
            end
          end
        end
        neuron_pkg::REFRACT: begin
          if (cnt_q == '0) state_d = WAIT_LO;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        WAIT_LO: begin
          if (bus.v_in < bus.thr_lo) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  assign pop  = ~empty & bus.ev_ready;
  assign drop = fire & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      spike_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      spike_q <= fire;
      if (bus.v_valid) ts_q <= ts_q + TS_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TS_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fire & ~drop),
    .din   (ts_q),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .empty (empty)
  );

  assign bus.spike     = spike_q;
  assign bus.ev_valid  = ~empty;
  assign bus.ev_ts     = head;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench: three encoder configurations share one stimulus stream and
// are compared every cycle against a sample-index/queue reference model.
module tb_spike_event_encoder;
  import neuron_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               v_valid = 1'b0;
  logic signed [15:0] v_in = '0;
  logic signed [15:0] thr_hi = Q_ONE;
  logic signed [15:0] thr_lo = 16'sd0;
  logic               ev_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spike_event_encoder_if #(.W(16), .TS_W(16)) if_a ();
  spike_event_encoder_if #(.W(16), .TS_W(16)) if_b ();
  spike_event_encoder_if #(.W(16), .TS_W(4))  if_c ();

  assign if_a.v_valid = v_valid;  assign if_a.v_in = v_in;  assign if_a.ev_ready = ev_ready;
  assign if_a.thr_hi  = thr_hi;   assign if_a.thr_lo = thr_lo;
  assign if_b.v_valid = v_valid;  assign if_b.v_in = v_in;  assign if_b.ev_ready = ev_ready;
  assign if_b.thr_hi  = thr_hi;   assign if_b.thr_lo = thr_lo;
  assign if_c.v_valid = v_valid;  assign if_c.v_in = v_in;  assign if_c.ev_ready = ev_ready;
  assign if_c.thr_hi  = thr_hi;   assign if_c.thr_lo = thr_lo;

  spike_event_encoder #(.W(16), .TS_W(16), .FIFO_DEPTH(4), .REFRACT(8)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  spike_event_encoder #(.W(16), .TS_W(16), .FIFO_DEPTH(4), .REFRACT(3)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  spike_event_encoder #(.W(16), .TS_W(4),  .FIFO_DEPTH(4), .REFRACT(0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // ---------------- reference model ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  int m_n[3];
  int m_last[3];
  bit m_armed[3];
  bit m_spike[3];
  bit m_ovf[3];
  int m_drop[3];

  function automatic int ref_of(input int d);
    case (d) 0: return 8; 1: return 3; default: return 0; endcase
  endfunction

  function automatic int ts_mod(input int d);
    return (d == 2) ? 16 : 65536;
  endfunction

  function automatic int q_size(input int d);
    case (d) 0: return exp_q0.size(); 1: return exp_q1.size(); default: return exp_q2.size(); endcase
  endfunction

  function automatic logic [15:0] q_front(input int d);
    case (d) 0: return exp_q0[0]; 1: return exp_q1[0]; default: return exp_q2[0]; endcase
  endfunction

  task automatic q_push(input int d, input logic [15:0] val);
    case (d) 0: exp_q0.push_back(val); 1: exp_q1.push_back(val); default: exp_q2.push_back(val); endcase
  endtask

  task automatic q_pop(input int d);
    case (d) 0: void'(exp_q0.pop_front()); 1: void'(exp_q1.pop_front()); default: void'(exp_q2.pop_front()); endcase
  endtask

  task automatic model_reset();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    for (int d = 0; d < 3; d++) begin
      m_n[d] = 0; m_last[d] = 0; m_armed[d] = 1'b1;
      m_spike[d] = 1'b0; m_ovf[d] = 1'b0; m_drop[d] = 0;
    end
  endtask

  // A fire at sample f blocks samples f+1..f+R; afterwards the first sample below
  // thr_lo re-arms (and cannot itself fire).
  task automatic model_step(input int d);
    bit fire;
    bit pop;
    fire = 1'b0;
    pop  = (q_size(d) > 0) && ev_ready;
    if (v_valid) begin
      if (m_armed[d] && (v_in >= thr_hi)) begin
        fire = 1'b1;
        m_armed[d] = 1'b0;
        m_last[d]  = m_n[d];
      end else if (!m_armed[d] && (m_n[d] > m_last[d] + ref_of(d)) && (v_in < thr_lo)) begin
        m_armed[d] = 1'b1;
      end
    end
    if (pop) q_pop(d);
    if (fire) begin
      if (q_size(d) < 4) q_push(d, 16'(m_n[d] % ts_mod(d)));
      else begin
        m_ovf[d] = 1'b1;
        if (m_drop[d] < 255) m_drop[d]++;
      end
    end
    m_spike[d] = fire;
    if (v_valid) m_n[d]++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_dut(input int d, output logic sp, output logic vl, output logic [15:0] ts,
                          output logic ov, output logic [7:0] dc, output logic [1:0] st);
    case (d)
      0: begin sp = if_a.spike; vl = if_a.ev_valid; ts = if_a.ev_ts; ov = if_a.overflow; dc = if_a.drop_cnt; st = if_a.dbg_state; end
      1: begin sp = if_b.spike; vl = if_b.ev_valid; ts = if_b.ev_ts; ov = if_b.overflow; dc = if_b.drop_cnt; st = if_b.dbg_state; end
      default: begin sp = if_c.spike; vl = if_c.ev_valid; ts = {12'd0, if_c.ev_ts}; ov = if_c.overflow; dc = if_c.drop_cnt; st = if_c.dbg_state; end
    endcase
  endtask

  task automatic check_model(input int d);
    logic sp, vl, ov;
    logic [15:0] ts;
    logic [7:0] dc;
    logic [1:0] st;
    read_dut(d, sp, vl, ts, ov, dc, st);
    chk($sformatf("model%0d spike", d), sp, m_spike[d]);
    chk($sformatf("model%0d ev_valid", d), vl, q_size(d) > 0);
    if (q_size(d) > 0) chk($sformatf("model%0d ev_ts", d), ts, q_front(d));
    chk($sformatf("model%0d overflow", d), ov, m_ovf[d]);
    chk($sformatf("model%0d drop_cnt", d), dc, m_drop[d]);
  endtask

  task automatic cycle();
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_model(d);
  endtask

  // Asserts reset mid-cycle and checks the reset values before any clock edge.
  task automatic do_reset();
    logic sp, vl, ov;
    logic [15:0] ts;
    logic [7:0] dc;
    logic [1:0] st;
    rst = 1'b0;
    model_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      read_dut(d, sp, vl, ts, ov, dc, st);
      chk($sformatf("rst%0d spike", d), sp, 0);
      chk($sformatf("rst%0d ev_valid", d), vl, 0);
      chk($sformatf("rst%0d ev_ts", d), ts, 0);
      chk($sformatf("rst%0d overflow", d), ov, 0);
      chk($sformatf("rst%0d drop_cnt", d), dc, 0);
      chk($sformatf("rst%0d state", d), st, ARMED);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drive(input bit vv, input int v, input bit rdy);
    v_valid  = vv;
    v_in     = 16'(v);
    ev_ready = rdy;
  endtask

  typedef struct {
    int dut; bit rst_first; bit vv; int v; bit rdy; bit e_spike; bit e_valid; int e_ts;
  } vec_t;
  vec_t vec[10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic sp, vl, ov;
    logic [15:0] ts;
    logic [7:0] dc;
    logic [1:0] st;
    int spikes;

    // basic fire on the REFRACT=8 unit, hysteresis on the REFRACT=0 unit
    vec[0] = '{0, 1, 1, -100, 1, 0, 0, 0};
    vec[1] = '{0, 0, 1, 2000, 1, 0, 0, 0};
    vec[2] = '{0, 0, 1, 5000, 1, 1, 1, 2};
    vec[3] = '{0, 0, 0, 0,    1, 0, 0, 0};
    vec[4] = '{2, 1, 1, 5000, 1, 1, 1, 0};
    vec[5] = '{2, 0, 1, 2000, 1, 0, 0, 0};
    vec[6] = '{2, 0, 1, 5000, 1, 0, 0, 0};
    vec[7] = '{2, 0, 1, -5,   1, 0, 0, 0};
    vec[8] = '{2, 0, 1, 5000, 1, 1, 1, 4};
    vec[9] = '{2, 0, 0, 0,    1, 0, 0, 0};

    for (int i = 0; i < 10; i++) begin
      if (vec[i].rst_first) do_reset();
      drive(vec[i].vv, vec[i].v, vec[i].rdy);
      cycle();
      read_dut(vec[i].dut, sp, vl, ts, ov, dc, st);
      chk($sformatf("vec%0d spike", i), sp, vec[i].e_spike);
      chk($sformatf("vec%0d ev_valid", i), vl, vec[i].e_valid);
      if (vec[i].e_valid) chk($sformatf("vec%0d ev_ts", i), ts, vec[i].e_ts);
    end

    // refractory on the REFRACT=3 unit: one spike over a long high run
    do_reset();
    spikes = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 5000, 1);
      cycle();
      spikes += int'(if_b.spike);
    end
    drive(1, -1, 1);
    cycle();
    spikes += int'(if_b.spike);
    chk("refract spike count", spikes, 1);
    drive(1, 5000, 1);
    cycle();
    chk("refract second spike", if_b.spike, 1);
    chk("refract second ev_ts", if_b.ev_ts, 11);

    // backpressure and overflow on the REFRACT=0 unit: fires at ts 0,2,..,10
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 5000, 0);
      cycle();
      chk("bp spike", if_c.spike, 1);
      chk("bp head held", if_c.ev_ts, 0);
      drive(1, -1, 0);
      cycle();
    end
    chk("bp overflow", if_c.overflow, 1);
    chk("bp drop_cnt", if_c.drop_cnt, 2);
    drive(0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk("bp drain valid", if_c.ev_valid, 1);
      chk("bp drain order", if_c.ev_ts, 2 * k);
      cycle();
    end
    chk("bp drained empty", if_c.ev_valid, 0);

    // full FIFO with push and pop on the same edge
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5000, 0); cycle();
      drive(1, -1, 0);   cycle();
    end
    drive(1, 5000, 1);
    cycle();
    chk("fullpp spike", if_c.spike, 1);
    chk("fullpp overflow", if_c.overflow, 0);
    chk("fullpp drop_cnt", if_c.drop_cnt, 0);
    drive(0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk("fullpp valid", if_c.ev_valid, 1);
      chk("fullpp order", if_c.ev_ts, 2 * k + 2);
      cycle();
    end
    chk("fullpp empty", if_c.ev_valid, 0);

    // timestamp wrap on the TS_W=4 unit, then reset with events queued
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1, -1, 0);
      cycle();
    end
    drive(1, 5000, 0);
    cycle();
    chk("wrap spike", if_c.spike, 1);
    chk("wrap ev_ts", if_c.ev_ts, 0);
    chk("wrap long ts", if_a.ev_ts, 16);
    drive(1, -1, 0);   cycle();
    drive(1, 5000, 0); cycle();
    chk("wrap queued head", if_c.ev_ts, 0);
    do_reset();
    drive(1, 5000, 1);
    cycle();
    chk("post-reset spike", if_c.spike, 1);
    chk("post-reset ev_ts", if_c.ev_ts, 0);

    // random stimulus against the model, including a misconfigured threshold phase
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if (i == 800) thr_lo = 16'sd6000;
      if (i == 1200) begin
        thr_lo = -16'sd3000;
        thr_hi = -16'sd1000;
      end
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 12000)) - 6000, $urandom_range(0, 2) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
